// File: rtl/dmem_responder.sv
// Data-memory responder for the pipelined core's M-stage port: word RAM plus a 16-byte I/O window.
// Optional STORES counter is built when DMEM_STORE_COUNT_EN is defined.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] MMIO_BASE   = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [31:0] gpio_out,
  output logic        done,
  output logic [31:0] tohost_val,
  output logic        err
);
  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   r_mem [DEPTH_WORDS];
  logic [31:0]   r_cycle;
  logic [31:0]   r_gpio;
  logic [31:0]   r_tohost;
  logic          r_done;
  logic          r_err;
  logic [31:0]   w_stores;

  logic          w_is_ram;
  logic          w_is_io;
  logic          w_aligned;
  logic [AW-1:0] w_ram_idx;
  logic [1:0]    w_io_off;
  logic          w_ram_we;
  logic          w_gpio_we;
  logic          w_tohost_we;
  logic          w_err_set;

  assign w_is_ram    = DataAdr < 32'(4 * DEPTH_WORDS);
  assign w_is_io     = DataAdr[31:4] == MMIO_BASE[31:4];
  assign w_aligned   = DataAdr[1:0] == 2'b00;
  assign w_ram_idx   = DataAdr[AW+1:2];
  assign w_io_off    = DataAdr[3:2];

  assign w_ram_we    = MemWrite && w_aligned && w_is_ram;
  assign w_gpio_we   = MemWrite && w_aligned && w_is_io && (w_io_off == 2'd1);
  assign w_tohost_we = MemWrite && w_aligned && w_is_io && (w_io_off == 2'd2);
  // Stores to the read-only I/O registers are dropped silently; only misaligned or unmapped stores flag err.
  assign w_err_set   = MemWrite && (!w_aligned || (!w_is_ram && !w_is_io));

  // RAM is never reset, but a store arriving while reset is held must not land.
  always_ff @(posedge clk) begin
    if (reset && w_ram_we) begin
      r_mem[w_ram_idx] <= WriteData;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycle  <= '0;
      r_gpio   <= '0;
      r_tohost <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_gpio_we) begin
        r_gpio <= WriteData;
      end
      if (w_tohost_we) begin
        r_tohost <= WriteData;
        r_done   <= 1'b1;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

`ifdef DMEM_STORE_COUNT_EN
  logic [31:0] r_stores;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stores <= '0;
    end else if (w_ram_we || w_gpio_we || w_tohost_we) begin
      r_stores <= r_stores + 32'd1;
    end
  end

  assign w_stores = r_stores;
`else
  assign w_stores = '0;
`endif

  always_comb begin
    ReadData = '0;
    if (w_is_ram) begin
      ReadData = r_mem[w_ram_idx];
    end else if (w_is_io) begin
      case (w_io_off)
        2'd0:    ReadData = r_cycle;
        2'd1:    ReadData = r_gpio;
        2'd2:    ReadData = r_tohost;
        default: ReadData = w_stores;
      endcase
    end
  end

  assign gpio_out   = r_gpio;
  assign done       = r_done;
  assign tohost_val = r_tohost;
  assign err        = r_err;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: read expectations go through a scoreboard queue,
// outputs are checked with immediate assertions.
module tb_dmem_responder;
  localparam logic [31:0] MB = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [31:0] gpio_out;
  logic        done;
  logic [31:0] tohost_val;
  logic        err;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] exp_q [$];
  logic [31:0] stores_exp;

  dmem_responder #(.DEPTH_WORDS(64), .MMIO_BASE(MB)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .ReadData(ReadData), .gpio_out(gpio_out),
    .done(done), .tohost_val(tohost_val), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h required %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    DataAdr   = a;
    WriteData = d;
    step();
    MemWrite  = 1'b0;
  endtask

  // Expected read value enters the scoreboard when the address is driven,
  // and is popped once the combinational output has settled.
  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    MemWrite = 1'b0;
    DataAdr  = a;
    exp_q.push_back(exp);
    #1;
    chk(tag, ReadData, exp_q.pop_front());
  endtask

  initial begin
    reset = 1'b0; MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
    step(); step();
    reset = 1'b1;
    st(32'h0, 32'h1111_1111);
    st(32'h3C, 32'hCAFE_0000);

    // Held reset with a live store: nothing may commit, RAM included.
    reset = 1'b0;
    MemWrite = 1'b1; DataAdr = 32'h0; WriteData = 32'hDEAD_BEEF;
    step(); step(); step();
    chk("rst_gpio", gpio_out, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_tohost", tohost_val, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    rd("rst_cycle", MB, 32'h0);
    rd("rst_rd_gpio", MB + 32'h4, 32'h0);
    rd("rst_stores", MB + 32'hC, 32'h0);
    reset = 1'b1;
    rd("ram_survives_rst", 32'h0, 32'h1111_1111);

    repeat (10) step();
    rd("cycle_after_10", MB, 32'd10);

    MemWrite = 1'b1; DataAdr = 32'h3C; WriteData = 32'h1234_5678;
    exp_q.push_back(32'hCAFE_0000);
    #1;
    chk("ram_same_cycle_old", ReadData, exp_q.pop_front());
    step();
    MemWrite = 1'b0;
    rd("ram_3c_new", 32'h3C, 32'h1234_5678);
    rd("ram_3e_new", 32'h3E, 32'h1234_5678);

    st(MB + 32'h4, 32'h0000_00A5);
    chk("gpio_out", gpio_out, 32'hA5);
    rd("rd_gpio", MB + 32'h4, 32'hA5);
    chk("done_before", {31'b0, done}, 32'h0);
    st(MB + 32'h8, 32'd7);
    chk("done_set", {31'b0, done}, 32'h1);
    chk("tohost_val", tohost_val, 32'd7);
    rd("rd_tohost", MB + 32'h8, 32'd7);
    chk("err_clean", {31'b0, err}, 32'h0);

    st(32'h2, 32'h0BAD_0BAD);
    chk("err_misaligned", {31'b0, err}, 32'h1);
    rd("ram0_unchanged", 32'h0, 32'h1111_1111);

    // Asynchronous reset away from any rising edge.
    #2 reset = 1'b0;
    #1;
    chk("async_err", {31'b0, err}, 32'h0);
    chk("async_done", {31'b0, done}, 32'h0);
    chk("async_gpio", gpio_out, 32'h0);
    chk("async_tohost", tohost_val, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    rd("rd_unmapped", 32'h800, 32'h0);
    chk("load_no_err", {31'b0, err}, 32'h0);
    st(MB + 32'h0, 32'h5555_5555);
    st(MB + 32'hC, 32'h6666_6666);
    chk("ro_store_no_err", {31'b0, err}, 32'h0);
    st(32'h800, 32'h7777_7777);
    chk("err_unmapped", {31'b0, err}, 32'h1);

    st(32'h10, 32'hABCD_0010);
    st(MB + 32'h4, 32'h0000_0042);
    st(MB + 32'h8, 32'h0000_0001);
    st(32'h6, 32'hFFFF_FFFF);
`ifdef DMEM_STORE_COUNT_EN
    stores_exp = 32'd3;
`else
    stores_exp = 32'd0;
`endif
    rd("stores_count", MB + 32'hC, stores_exp);
    rd("ram_10", 32'h10, 32'hABCD_0010);
    chk("gpio_42", gpio_out, 32'h42);

    dut.r_cycle = 32'hFFFF_FFFF;
    rd("cycle_max", MB, 32'hFFFF_FFFF);
    step();
    rd("cycle_wrap", MB, 32'h0);
    step();
    rd("cycle_after_wrap", MB, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
